mult_div_unit: RTL and testbench
================================

# mult_div_unit

Parametrised iterative multiply/divide unit with architectural HI/LO registers, the multi-cycle companion to the combinational ALU in the MIPS datapath. Executes MULT, MULTU, DIV, DIVU over several cycles with a start/busy/done handshake, and services MTHI/MTLO writes. The pipeline stalls on `busy` and reads `hi`/`lo` for MFHI/MFLO.

## Interface
- `WIDTH`, default 32: operand width and HI/LO width; even, ≥ 4.
- `clk`  in  1  sole clock; all state updates on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  request; sampled on a rising edge only while `busy`=0.
- `op`  in  3  operation: 000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO; 110/111 ignored.
- `arg1`  in  WIDTH  multiplicand/dividend; data source for MTHI/MTLO.
- `arg2`  in  WIDTH  multiplier/divisor.
- `flush`  in  1  abandon the in-flight op.
- `busy`  out  1  op in progress; reset 0.
- `done`  out  1  one-cycle pulse when HI/LO are updated; reset 0.
- `div_zero`  out  1  latched: last completed DIV/DIVU had divisor 0; reset 0.
- `hi`  out  WIDTH  HI register; reset 0.
- `lo`  out  WIDTH  LO register; reset 0.

## Operation
- FSM states: IDLE, CALC, FIX. Reset → IDLE.
- IDLE + `start` + MULT/MULTU/DIV/DIVU: latch operand magnitudes and result sign. Go to CALC. Iteration counter = WIDTH. `busy`←1.
- CALC: one shift-add (multiply) or restoring-subtract (divide) step per cycle. Counter decrements. At 0 go to FIX.
- FIX: apply sign correction and write HI/LO. Pulse `done`. `busy`←0. Go to IDLE.
- Multiply: {hi,lo} = full 2·WIDTH product, signed (MULT) or unsigned (MULTU).
- Divide: lo = quotient, hi = remainder. Signed division truncates toward zero. The remainder takes the sign of the dividend.
- Divisor 0: lo = all ones, hi = arg1, `div_zero`←1. Any other completed DIV/DIVU clears `div_zero`. Multiplies leave it unchanged.
- Signed overflow (most-negative / −1): lo = most-negative, hi = 0. `div_zero`=0.
- MTHI/MTLO in IDLE: write `arg1` to hi/lo on the sampling edge. `done` pulses the next cycle. `busy` stays 0.
- Ops 110/111: no effect, no `done`.
- `start` while `busy`=1: ignored entirely, including MTHI/MTLO.
- `flush`: from CALC/FIX, go to IDLE on the next edge. `busy`←0, no `done`, hi/lo/`div_zero` unchanged. `flush` in IDLE with `start` high: flush wins, start dropped.
- `rst_n` low at any time, including mid-CALC: all outputs and state return to reset values immediately.

## Timing
- Start sampled at edge E0. `busy`=1 after E0 through E(WIDTH+1).
- hi/lo written at E(WIDTH+1). `done`=1 for exactly the cycle following E(WIDTH+1). Total latency WIDTH+1 edges, i.e. 33 for WIDTH=32.
- New `start` may be sampled on the edge that ends the `done` cycle. Back-to-back issue rate is WIDTH+2 cycles.
- `hi`/`lo` are registered outputs and stable except at the write edge.

## Configuration
- `MDU_FAST_MULT_EN` defined: MULT/MULTU use a single registered WIDTH×WIDTH multiply. IDLE → FIX directly. hi/lo are written at E1, `done` is high in the cycle after E1, and `busy` is high for one cycle. Division is unchanged.
- Not defined: multiply uses the iterative CALC path. No hardware multiplier is inferred.

## Structure
- Package `mdu_pkg`: op encoding enum (`mdu_op_e`), FSM state enum, `MDU_OP_W = 3`.
- Sub-module `mdu_divider`: unsigned restoring-divide datapath (remainder/quotient shift registers, one step per enable). The top level owns the FSM, sign handling, HI/LO and multiply.

## Test plan
All with WIDTH=32, macro off unless stated.
- MULT arg1=0xFFFFFFFF, arg2=0x00000002 → hi=0xFFFFFFFF, lo=0xFFFFFFFE, `done` in the cycle after E33, `busy` high for 33 cycles.
- MULTU same operands → hi=0x00000001, lo=0xFFFFFFFE. With `MDU_FAST_MULT_EN`, same result with `done` in the cycle after E1.
- DIV 0xFFFFFFF9 (−7) / 0x00000002 → lo=0xFFFFFFFD, hi=0xFFFFFFFF. Then DIV 0x80000000 / 0xFFFFFFFF → lo=0x80000000, hi=0, `div_zero`=0.
- DIVU 7 / 0 → lo=0xFFFFFFFF, hi=0x00000007, `div_zero`=1. A following DIVU 9/3 → lo=3, hi=0, `div_zero`=0.
- Preload hi=0x1234 via MTHI. Start DIVU, assert `flush` on the 10th busy cycle → `busy`=0 next cycle, no `done`, hi=0x1234. A MTLO issued mid-CALC is ignored.
- Deassert `rst_n` mid-CALC of MULT → hi=lo=0, `busy`=`done`=`div_zero`=0 immediately. After release, a new MULT 3×5 gives lo=15, hi=0.

Source files
------------

// File: rtl/mdu_pkg.sv
// Shared encodings for the multiply/divide unit: op codes, FSM states and op field width.
package mdu_pkg;

    localparam int unsigned MDU_OP_W = 3;

    typedef enum logic [MDU_OP_W-1:0] {
        OpMult  = 3'b000,
        OpMultu = 3'b001,
        OpDiv   = 3'b010,
        OpDivu  = 3'b011,
        OpMthi  = 3'b100,
        OpMtlo  = 3'b101
    } mdu_op_e;

    typedef enum logic [1:0] {
        StIdle,
        StCalc,
        StFix
    } mdu_state_e;

endpackage

// File: rtl/mdu_divider.sv
// Unsigned restoring divider: one quotient bit per enabled cycle, WIDTH steps per divide.
module mdu_divider #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             en,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);

    logic [WIDTH-1:0] rem_q, quo_q, dsr_q;
    logic [WIDTH:0]   trial;

    // MSB of the trial difference is the borrow: set means the divisor did not fit.
    assign trial = {rem_q, quo_q[WIDTH-1]} - {1'b0, dsr_q};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem_q <= '0;
            quo_q <= '0;
            dsr_q <= '0;
        end else if (load) begin
            rem_q <= '0;
            quo_q <= dividend;
            dsr_q <= divisor;
        end else if (en) begin
            if (!trial[WIDTH]) begin
                rem_q <= trial[WIDTH-1:0];
                quo_q <= {quo_q[WIDTH-2:0], 1'b1};
            end else begin
                rem_q <= {rem_q[WIDTH-2:0], quo_q[WIDTH-1]};
                quo_q <= {quo_q[WIDTH-2:0], 1'b0};
            end
        end
    end

    assign quotient  = quo_q;
    assign remainder = rem_q;

endmodule

// File: rtl/mult_div_unit.sv
// Iterative MIPS multiply/divide unit with HI/LO registers and start/busy/done handshake.
// Optional MDU_FAST_MULT_EN: single-cycle registered multiply instead of shift-add.
module mult_div_unit
    import mdu_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [MDU_OP_W-1:0] op,
    input  logic [WIDTH-1:0]    arg1,
    input  logic [WIDTH-1:0]    arg2,
    input  logic                flush,
    output logic                busy,
    output logic                done,
    output logic                div_zero,
    output logic [WIDTH-1:0]    hi,
    output logic [WIDTH-1:0]    lo
);

    localparam int unsigned CW = $clog2(WIDTH + 1);

    mdu_state_e state_q, state_d;
    mdu_op_e    op_e;
    logic [CW-1:0] cnt_q, cnt_d;
    logic launch, step, commit, accept, mt_write;
    logic is_div_q, neg_q, rneg_q, bzero_q, done_q, dz_q;
    logic signed_op, a1_neg, a2_neg;
    logic [WIDTH-1:0] a1_mag, a2_mag, a1_q, mcand_q, hi_q, lo_q, quo_mag, rem_mag;
    logic [WIDTH:0] acc_sum;
    logic [2*WIDTH-1:0] prod_q, mul_mag, mul_res;

    assign op_e      = mdu_op_e'(op);
    assign accept    = (state_q == StIdle) && start && !flush;
    assign mt_write  = accept && ((op_e == OpMthi) || (op_e == OpMtlo));
    assign signed_op = !op[0];
    assign a1_neg    = signed_op && arg1[WIDTH-1];
    assign a2_neg    = signed_op && arg2[WIDTH-1];
    assign a1_mag    = a1_neg ? -arg1 : arg1;
    assign a2_mag    = a2_neg ? -arg2 : arg2;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        launch  = 1'b0;
        step    = 1'b0;
        commit  = 1'b0;
        case (state_q)
            StIdle: begin
                if (accept && !op[MDU_OP_W-1]) begin
                    launch = 1'b1;
                    cnt_d  = CW'(WIDTH);
`ifdef MDU_FAST_MULT_EN
                    state_d = op[1] ? StCalc : StFix;
`else
                    state_d = StCalc;
`endif
                end
            end
            StCalc: begin
                if (flush) begin
                    state_d = StIdle;
                end else begin
                    step  = 1'b1;
                    cnt_d = cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) state_d = StFix;
                end
            end
            StFix: begin
                state_d = StIdle;
                commit  = !flush;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Shift-add step: multiplier drains out of the low half as the product fills the top.
    assign acc_sum = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + {1'b0, (prod_q[0] ? mcand_q : '0)};

`ifdef MDU_FAST_MULT_EN
    assign mul_mag = {{WIDTH{1'b0}}, mcand_q} * {{WIDTH{1'b0}}, prod_q[WIDTH-1:0]};
`else
    assign mul_mag = prod_q;
`endif
    assign mul_res = neg_q ? -mul_mag : mul_mag;

    mdu_divider #(
        .WIDTH(WIDTH)
    ) u_divider (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (launch && op[1]),
        .en       (step && is_div_q),
        .dividend (a1_mag),
        .divisor  (a2_mag),
        .quotient (quo_mag),
        .remainder(rem_mag)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            is_div_q <= 1'b0;
            neg_q    <= 1'b0;
            rneg_q   <= 1'b0;
            bzero_q  <= 1'b0;
            a1_q     <= '0;
            mcand_q  <= '0;
            prod_q   <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            done_q   <= 1'b0;
            dz_q     <= 1'b0;
        end else begin
            done_q <= commit || mt_write;
            if (launch) begin
                is_div_q <= op[1];
                neg_q    <= a1_neg ^ a2_neg;
                rneg_q   <= a1_neg;
                bzero_q  <= (arg2 == '0);
                a1_q     <= arg1;
                mcand_q  <= a1_mag;
                prod_q   <= {{WIDTH{1'b0}}, a2_mag};
            end else if (step && !is_div_q) begin
                prod_q <= {acc_sum, prod_q[WIDTH-1:1]};
            end
            if (mt_write) begin
                if (op_e == OpMthi) hi_q <= arg1;
                else                lo_q <= arg1;
            end
            if (commit) begin
                if (!is_div_q) begin
                    {hi_q, lo_q} <= mul_res;
                end else if (bzero_q) begin
                    lo_q <= '1;
                    hi_q <= a1_q;
                    dz_q <= 1'b1;
                end else begin
                    // Quotient truncates toward zero; remainder follows the dividend's sign.
                    lo_q <= neg_q ? -quo_mag : quo_mag;
                    hi_q <= rneg_q ? -rem_mag : rem_mag;
                    dz_q <= 1'b0;
                end
            end
        end
    end

    assign busy     = (state_q != StIdle);
    assign done     = done_q;
    assign div_zero = dz_q;
    assign hi       = hi_q;
    assign lo       = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed vector table, corner sequences, random ops.
module tb_mult_div_unit;

    logic        clk = 1'b0;
    logic        rst_n, start, flush, busy, done, div_zero;
    logic [2:0]  op;
    logic [31:0] arg1, arg2, hi, lo;

    int n_cmp = 0;
    int n_fail = 0;
    logic [31:0] m_hi = '0, m_lo = '0;
    logic        m_dz = 1'b0;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a1;
        logic [31:0] a2;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
    } vec_t;

    vec_t vecs[12];

    mult_div_unit #(
        .WIDTH(32)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .op      (op),
        .arg1    (arg1),
        .arg2    (arg2),
        .flush   (flush),
        .busy    (busy),
        .done    (done),
        .div_zero(div_zero),
        .hi      (hi),
        .lo      (lo)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input int id, input logic [63:0] act,
                       input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s[%0d]: got %0h expected %0h", name, id, act, exp);
        end
    endtask

    // Reference behaviour from plain integer arithmetic.
    task automatic model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (o)
            3'd0: begin p = sa * sb; m_hi = p[63:32]; m_lo = p[31:0]; end
            3'd1: begin p = {32'h0, a} * {32'h0, b}; m_hi = p[63:32]; m_lo = p[31:0]; end
            3'd2, 3'd3: begin
                if (b == 32'h0) begin
                    m_lo = 32'hffff_ffff; m_hi = a; m_dz = 1'b1;
                end else begin
                    if (o == 3'd2) begin q = sa / sb; r = sa % sb; end
                    else begin q = longint'(a / b); r = longint'(a % b); end
                    m_lo = q[31:0]; m_hi = r[31:0]; m_dz = 1'b0;
                end
            end
            3'd4: m_hi = a;
            3'd5: m_lo = a;
            default: ;
        endcase
    endtask

    function automatic int exp_lat(input logic [2:0] o);
        if (o >= 3'd4) return 0;
`ifdef MDU_FAST_MULT_EN
        if (o < 3'd2) return 1;
`endif
        return 33;
    endfunction

    task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                         output int lat, output int nbusy);
        @(negedge clk);
        op = o; arg1 = a; arg2 = b; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 0;
        nbusy = busy ? 1 : 0;
        while (!done && lat < 100) begin
            @(posedge clk); #1;
            lat++;
            if (busy) nbusy++;
        end
    endtask

    task automatic run_chk(input int id, input logic [2:0] o, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el,
                           input logic edz);
        int lat, nb;
        issue(o, a, b, lat, nb);
        chk("latency", id, lat, exp_lat(o));
        chk("busy_cycles", id, nb, exp_lat(o));
        chk("hi", id, hi, eh);
        chk("lo", id, lo, el);
        chk("div_zero", id, div_zero, edz);
        @(posedge clk); #1;
        chk("done_width", id, done, 1'b0);
    endtask

    initial begin
        int lat, nb;
        logic seen;
        logic [2:0] o;
        logic [31:0] a, b;

        vecs[0]  = '{3'd0, 32'hffff_ffff, 32'h2, 32'hffff_ffff, 32'hffff_fffe, 1'b0};
        vecs[1]  = '{3'd1, 32'hffff_ffff, 32'h2, 32'h0000_0001, 32'hffff_fffe, 1'b0};
        vecs[2]  = '{3'd2, 32'hffff_fff9, 32'h2, 32'hffff_ffff, 32'hffff_fffd, 1'b0};
        vecs[3]  = '{3'd2, 32'h8000_0000, 32'hffff_ffff, 32'h0, 32'h8000_0000, 1'b0};
        vecs[4]  = '{3'd3, 32'h7, 32'h0, 32'h7, 32'hffff_ffff, 1'b1};
        vecs[5]  = '{3'd1, 32'h3, 32'h5, 32'h0, 32'hf, 1'b1};
        vecs[6]  = '{3'd3, 32'h9, 32'h3, 32'h0, 32'h3, 1'b0};
        vecs[7]  = '{3'd2, 32'h7, 32'hffff_fffe, 32'h1, 32'hffff_fffd, 1'b0};
        vecs[8]  = '{3'd2, 32'hffff_fff8, 32'h0, 32'hffff_fff8, 32'hffff_ffff, 1'b1};
        vecs[9]  = '{3'd0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0, 1'b1};
        vecs[10] = '{3'd3, 32'hffff_ffff, 32'h1, 32'h0, 32'hffff_ffff, 1'b0};
        vecs[11] = '{3'd0, 32'h7fff_ffff, 32'hffff_ffff, 32'hffff_ffff, 32'h8000_0001, 1'b0};

        rst_n = 1'b0; start = 1'b0; flush = 1'b0; op = '0; arg1 = '0; arg2 = '0;
        #12;
        chk("rst_busy", 0, busy, 1'b0);
        chk("rst_done", 0, done, 1'b0);
        chk("rst_dz", 0, div_zero, 1'b0);
        chk("rst_hi", 0, hi, 32'h0);
        chk("rst_lo", 0, lo, 32'h0);
        @(negedge clk); rst_n = 1'b1;

        for (int i = 0; i < 12; i++) begin
            run_chk(i, vecs[i].op, vecs[i].a1, vecs[i].a2, vecs[i].hi, vecs[i].lo, vecs[i].dz);
            model(vecs[i].op, vecs[i].a1, vecs[i].a2);
        end

        // MTHI preload, then flush a DIVU on its 10th busy cycle with an ignored MTLO inside.
        model(3'd4, 32'h1234, 32'h0);
        run_chk(100, 3'd4, 32'h1234, 32'h0, m_hi, m_lo, m_dz);
        @(negedge clk);
        op = 3'd3; arg1 = 32'd100; arg2 = 32'd7; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        op = 3'd5; arg1 = 32'hdead_beef; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("flush_pre_busy", 101, busy, 1'b1);
        @(negedge clk); flush = 1'b1;
        @(posedge clk); #1;
        chk("flush_busy", 101, busy, 1'b0);
        chk("flush_done", 101, done, 1'b0);
        chk("flush_hi", 101, hi, 32'h1234);
        chk("flush_lo", 101, lo, m_lo);
        @(negedge clk); flush = 1'b0;
        seen = 1'b0;
        repeat (40) begin @(posedge clk); #1; if (done) seen = 1'b1; end
        chk("flush_no_done", 101, seen, 1'b0);

        // Flush in IDLE beats a simultaneous start.
        @(negedge clk);
        op = 3'd4; arg1 = 32'h5555; flush = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        chk("idle_flush_done", 102, done, 1'b0);
        chk("idle_flush_hi", 102, hi, m_hi);
        @(negedge clk); op = 3'd2;
        @(posedge clk); #1;
        chk("idle_flush_busy", 102, busy, 1'b0);
        @(negedge clk); start = 1'b0; flush = 1'b0;

        // Asynchronous reset mid-CALC with div_zero set and nonzero HI.
        model(3'd3, 32'h7, 32'h0);
        run_chk(103, 3'd3, 32'h7, 32'h0, m_hi, m_lo, m_dz);
        @(negedge clk);
        op = 3'd0; arg1 = 32'h1234_5678; arg2 = 32'h9abc_def0; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk); rst_n = 1'b0; #1;
        chk("arst_busy", 104, busy, 1'b0);
        chk("arst_done", 104, done, 1'b0);
        chk("arst_dz", 104, div_zero, 1'b0);
        chk("arst_hi", 104, hi, 32'h0);
        chk("arst_lo", 104, lo, 32'h0);
        m_hi = '0; m_lo = '0; m_dz = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        model(3'd0, 32'd3, 32'd5);
        run_chk(105, 3'd0, 32'd3, 32'd5, 32'h0, 32'd15, 1'b0);

        for (int i = 0; i < 60; i++) begin
            o = 3'($urandom_range(0, 7));
            a = $urandom;
            case ($urandom_range(0, 9))
                0: b = 32'h0;
                1: b = 32'hffff_ffff;
                2: begin a = 32'h8000_0000; b = 32'hffff_ffff; end
                3, 4: b = $urandom_range(1, 20);
                default: b = $urandom;
            endcase
            if (o >= 3'd6) begin
                @(negedge clk);
                op = o; arg1 = a; arg2 = b; start = 1'b1;
                @(posedge clk); #1; start = 1'b0;
                seen = 1'b0;
                repeat (5) begin
                    if (done || busy) seen = 1'b1;
                    @(posedge clk); #1;
                end
                chk("nop_activity", 200 + i, seen, 1'b0);
                chk("nop_hi", 200 + i, hi, m_hi);
                chk("nop_lo", 200 + i, lo, m_lo);
            end else begin
                model(o, a, b);
                run_chk(200 + i, o, a, b, m_hi, m_lo, m_dz);
            end
        end

        issue(3'd1, 32'hffff_ffff, 32'h2, lat, nb);
        chk("final_lat", 300, lat, exp_lat(3'd1));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
